keypad_cmd_encoder: RTL

- Front-end command source for calc_top: scans a 4x4 matrix keypad, debounces each press and emits the 4-bit cmd code that calc_top consumes.
- It is the producer side of the calc_top cmd interface and sits between the board keypad pins and calc_top.cmd.
- cmd holds the key code for as long as the key is held, then returns to the idle code.
- A one-cycle cmd_valid pulse marks each new, debounced press.

---
 rtl/calc_pkg.sv | 61 ++++++
 rtl/key_sync.sv | 32 +++
 rtl/keypad_cmd_encoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator front end and calc_top.
//   - 4-bit command codes carried on the cmd interface
//   - keypad FSM state type
//   - keypad (row, col) to command code lookup
//   - lowest-index low row picker for the scan sample
package calc_pkg;

    localparam logic [3:0] CMD_ADD  = 4'b1010;
    localparam logic [3:0] CMD_SUB  = 4'b1011;
    localparam logic [3:0] CMD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_CLR  = 4'b1101;
    localparam logic [3:0] CMD_EQ   = 4'b1110;
    localparam logic [3:0] CMD_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Key map; (3,3) is not wired to a command and maps to CMD_IDLE.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = CMD_IDLE;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = CMD_ADD;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = CMD_SUB;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = CMD_MUL;
            4'b11_00: code = CMD_CLR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = CMD_EQ;
            default:  code = CMD_IDLE;
        endcase
        return code;
    endfunction

    function automatic logic key_is_used(input logic [1:0] row, input logic [1:0] col);
        return !((row == 2'd3) && (col == 2'd3));
    endfunction

    // Rows are active-low; when several are low the lowest index wins.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: WIDTH-bit two-flop synchronizer for asynchronous inputs.
// Synchronous active-high reset loads all-ones (the idle level of the
// pulled-up keypad rows).
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_d     asynchronous input bus
//   o_q     synchronized output bus
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_cmd_encoder.sv
// keypad_cmd_encoder: scans a 4x4 active-low matrix keypad, debounces each
// press and release, and drives the 4-bit command code consumed by calc_top.
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   row_in     keypad rows, active-low, asynchronous
//   col_out    keypad column drive, active-low one-hot
//   cmd        command code (IDLE_CMD when no key is accepted)
//   cmd_valid  one-cycle pulse when cmd takes a new key code
//   key_held   high while an accepted key is held
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | rotate columns, sample rows on last cycle of each slot
// DEBOUNCE | column frozen, counting consecutive low samples of the row
// HOLD     | key accepted, cmd held, waiting for the row to read high
// RELEASE  | counting consecutive high samples before returning to idle
module keypad_cmd_encoder
    import calc_pkg::*;
#(
    parameter int         SCAN_DIV        = 4,
    parameter int         DEBOUNCE_CYCLES = 8,
    parameter logic [3:0] IDLE_CMD        = CMD_IDLE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       w_row_s;
    logic             w_row_bit;
    logic [CNT_W-1:0] w_cnt_inc;

    kp_state_t        r_state,     w_state_nxt;
    logic [DIV_W-1:0] r_div,       w_div_nxt;
    logic [1:0]       r_col,       w_col_nxt;
    logic [1:0]       r_row,       w_row_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [3:0]       r_cmd,       w_cmd_nxt;
    logic             r_cmd_valid, w_cmd_valid_nxt;
    logic             r_key_held,  w_key_held_nxt;

    key_sync #(.WIDTH(4)) u_row_sync (
        .i_clk (clock),
        .i_rst (reset),
        .i_d   (row_in),
        .o_q   (w_row_s)
    );

    assign w_row_bit = w_row_s[r_row];
    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= SCAN;
            r_div       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_cmd       <= IDLE_CMD;
            r_cmd_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_col_nxt       = r_col;
        w_row_nxt       = r_row;
        w_cnt_nxt       = r_cnt;
        w_cmd_nxt       = r_cmd;
        w_cmd_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;

        unique case (r_state)
            SCAN: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (w_row_s != 4'b1111) begin
                        // The scan sample is the first of the stable samples.
                        w_state_nxt = DEBOUNCE;
                        w_row_nxt   = first_low_row(w_row_s);
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end

            DEBOUNCE: begin
                if (w_row_bit) begin
                    w_state_nxt = SCAN;
                    w_col_nxt   = r_col + 2'd1;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == CNT_DONE) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    // The unused key walks through HOLD/RELEASE silently.
                    if (key_is_used(r_row, r_col)) begin
                        w_cmd_nxt       = key_code(r_row, r_col);
                        w_cmd_valid_nxt = 1'b1;
                        w_key_held_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            HOLD: begin
                if (w_row_bit) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = CNT_ONE;
                end
            end

            RELEASE: begin
                if (!w_row_bit) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == CNT_DONE) begin
                    w_state_nxt    = SCAN;
                    w_cmd_nxt      = IDLE_CMD;
                    w_key_held_nxt = 1'b0;
                    w_col_nxt      = '0;
                    w_div_nxt      = '0;
                    w_cnt_nxt      = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    assign col_out   = ~(4'b0001 << r_col);
    assign cmd       = r_cmd;
    assign cmd_valid = r_cmd_valid;
    assign key_held  = r_key_held;

endmodule
